imem_boot_loader: RTL
=====================

# imem_boot_loader

Upstream boot stage for the single-cycle MIPS CPU. Receives a program image as a byte stream over a valid/ready link, writes it word by word into instruction memory, and verifies a checksum. Holds the CPU in reset until the image is complete and valid, then releases it after a fixed hold delay.

## Interface
- `DEPTH`, default 64: instruction-memory depth in 32-bit words; legal range 1..255.
- `ADDR_W`, default 6: instruction-memory word-address width; ceil(log2(DEPTH)).
- `RST_HOLD`, default 2: cycles between checksum pass and `cpu_rst_` release; minimum 1.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader can accept a byte.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address for the write.
- `imem_wdata`  out  32  instruction word for the write.
- `cpu_rst_`  out  1  active-low reset to the CPU; low until release.
- `done`  out  1  image loaded, checksum passed, CPU released.
- `err`  out  1  load failed; sticky until `rst_`.

## Operation
- Handshake: a byte transfers on any rising edge where `rx_valid && rx_ready`. `rx_valid` may drop between bytes at any time; the loader just waits.
- Stream format:
  - Byte 0 is the word count N.
  - Next come 4*N bytes, big-endian per word (first byte becomes bits 31:24).
  - Last comes 1 checksum byte, equal to the XOR of all 4*N data bytes. The count byte is not included.
- States:
  - HDR: `rx_ready`=1. On transfer, latch N.
    - N==0 or N>DEPTH goes to ERR.
    - Otherwise clear the byte counter, word counter and running XOR, then go to LOAD.
  - LOAD: `rx_ready`=1. Each transfer shifts the byte into a 32-bit assembly register and XORs it into the checksum.
    - On the 4th byte of a word, register `imem_wdata` and `imem_addr`=word counter. Pulse `imem_we` on the next cycle and increment the word counter.
    - After word N-1's 4th byte, go to CHK.
  - CHK: `rx_ready`=1. On transfer, compare the byte with the running XOR. Equal goes to HOLD; unequal goes to ERR.
  - HOLD: `rx_ready`=0. Count RST_HOLD cycles, then go to RUN.
  - RUN: `rx_ready`=0, `cpu_rst_`=1, `done`=1. Terminal state.
  - ERR: `rx_ready`=0, `err`=1, `cpu_rst_`=0. Terminal state.
- Memory writes already issued before an ERR are not undone. `cpu_rst_` is never released after ERR.
- The word counter spans 0..DEPTH-1 and never wraps; N≤DEPTH guarantees this.

## Timing
- Reset values (asynchronous, immediate on `rst_` low):
  - State HDR.
  - `rx_ready`=0 while `rst_` is low, then 1 from the first edge after release.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `cpu_rst_`=0, `done`=0, `err`=0.
- Write latency: `imem_we` is high for exactly the one cycle following the edge that accepted a word's 4th byte. `imem_addr` and `imem_wdata` are stable during that cycle.
- Back-to-back words at full rate produce `imem_we` pulses every 4 cycles. No transfer is stalled by a write; `rx_ready` stays high through LOAD.
- When the final word's write pulse and the checksum acceptance land on the same edge, both take effect.
- Release latency: the checksum is accepted on edge E. The state is in HOLD after E. `cpu_rst_` and `done` go high after edge E+RST_HOLD.
- `done` and `cpu_rst_` rise on the same edge. `err` rises on the edge that accepted the offending byte.
- `rst_` asserted mid-load returns to HDR and drives `cpu_rst_` low immediately. The next stream is parsed from its count byte.

## Test plan
- Load N=1, word 0x20080005 (bytes 20 08 00 05), checksum 0x2D → one `imem_we` with addr 0 and data 0x20080005. `cpu_rst_`/`done` go high 2 cycles after the checksum edge; `err`=0.
- Load N=64 at full rate with an incrementing pattern and correct XOR → 64 pulses, addr 0..63 in order, one pulse every 4 cycles, then release.
- Load N=3 with a corrupted checksum byte → 3 writes occur, then `err`=1. `cpu_rst_` stays 0 and `rx_ready`=0 for 100 further cycles.
- Count byte 0x00, and separately 0x41 (N=65 > DEPTH) → `err`=1 on that edge, no `imem_we` ever.
- N=2 with random 0–5 cycle gaps on `rx_valid` → same writes and data as the gap-free case, only delayed.
- Pulse `rst_` low after 5 bytes of an N=4 load, then send a fresh N=1 image → `cpu_rst_` low throughout the reset, the new word is written at addr 0, and the CPU is released normally.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a counted, checksummed byte image, writes it into
// instruction memory, then releases the CPU reset after a hold delay.
module imem_boot_loader #(
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6,
  parameter int RST_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_HDR, S_LOAD, S_CHK, S_HOLD, S_RUN, S_ERR
  } state_e;

  localparam logic [8:0]  DEPTH_V   = 9'(DEPTH);
  localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);

  state_e            state_q, state_d;
  logic              init_q;
  logic [7:0]        n_q, n_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        xor_q, xor_d;
  logic [15:0]       hold_q, hold_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              xfer;

  // rx_ready stays low until the first edge after reset release
  assign rx_ready = init_q &&
    (state_q == S_HDR || state_q == S_LOAD || state_q == S_CHK);
  assign xfer       = rx_valid && rx_ready;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst_   = (state_q == S_RUN);
  assign done       = (state_q == S_RUN);
  assign err        = (state_q == S_ERR);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_HDR;
      init_q  <= 1'b0;
      n_q     <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      asm_q   <= '0;
      xor_q   <= '0;
      hold_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      n_q     <= n_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      asm_q   <= asm_d;
      xor_q   <= xor_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    asm_d   = asm_q;
    xor_d   = xor_q;
    hold_d  = hold_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_HDR: begin
        if (xfer) begin
          n_d = rx_data;
          if (rx_data == 8'd0 || {1'b0, rx_data} > DEPTH_V) begin
            state_d = S_ERR;
          end else begin
            bcnt_d  = '0;
            wcnt_d  = '0;
            xor_d   = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          asm_d  = {asm_q[15:0], rx_data};
          xor_d  = xor_q ^ rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = wcnt_q[ADDR_W-1:0];
            wdata_d = {asm_q, rx_data};
            wcnt_d  = wcnt_q + 8'd1;
            if (wcnt_q == n_q - 8'd1) state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (xfer) begin
          hold_d  = '0;
          state_d = (rx_data == xor_q) ? S_HOLD : S_ERR;
        end
      end
      S_HOLD: begin
        hold_d = hold_q + 16'd1;
        if (hold_q == HOLD_LAST) state_d = S_RUN;
      end
      default: ;
    endcase
  end

endmodule
